sprite_palette_bank: RTL and testbench

Programmable multi-palette colour lookup for sprite and tile renderers: converts a per-pixel colour index plus palette select into RGB with two-cycle pipelined latency. Holds NUM_PAL run-time-writable palettes, flags a transparency key, and animates a fixed index range by palette cycling (water, lava, flashing power-ups). Sits between the sprite ROM fetch and the VGA colour mux, and replaces the fixed per-character ROM palettes.

---
 rtl/sprite_palette_pkg.sv | 33 +++
 rtl/sprite_palette_bank_cycle.sv | 50 +++++
 rtl/sprite_palette_bank.sv | 150 +++++++++++++++
 tb/tb_sprite_palette_bank.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/sprite_palette_pkg.sv
// Shared types and defaults for the sprite palette bank: RGB entry layout,
// reset palette contents and derived width helpers.
package sprite_palette_pkg;

  localparam int IDX_W          = 4;
  localparam int CH_W           = 4;
  localparam int DEPTH          = 1 << IDX_W;
  localparam int DEF_NUM_PAL    = 4;
  localparam int DEF_TRANSP_IDX = 0;
  localparam int DEF_CYC_FIRST  = 1;
  localparam int DEF_CYC_LAST   = 3;
  localparam int DEF_CYC_FRAMES = 8;
  localparam int DEF_PAL_W      = $clog2(DEF_NUM_PAL);
  localparam int DEF_LEN        = DEF_CYC_LAST - DEF_CYC_FIRST + 1;

  typedef struct packed {
    logic [CH_W-1:0] r;
    logic [CH_W-1:0] g;
    logic [CH_W-1:0] b;
  } rgb_t;

  // Reset colour is a grey ramp: each channel carries the index LSBs.
  function automatic rgb_t default_entry(input logic [IDX_W-1:0] i);
    logic [CH_W-1:0] c;
    c = CH_W'(i);
    return '{r: c, g: c, b: c};
  endfunction

  function automatic int width_of(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sprite_palette_bank_cycle.sv
// Palette-cycling timebase: counts frames and steps the rotation phase
// every CYC_FRAMES frames while cycling is enabled.
module palette_cycle_ctrl
  import sprite_palette_pkg::*;
#(
  parameter int LEN        = DEF_LEN,
  parameter int CYC_FRAMES = DEF_CYC_FRAMES,
  parameter int PH_W       = width_of(LEN)
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            frame_start_i,
  input  logic            cyc_en_i,
  output logic [PH_W-1:0] phase_o
);

  localparam int FC_W = width_of(CYC_FRAMES);

  logic [FC_W-1:0] cnt_q, cnt_d;
  logic [PH_W-1:0] phase_q, phase_d;

  always_comb begin
    cnt_d   = cnt_q;
    phase_d = phase_q;
    if (!cyc_en_i) begin
      cnt_d   = '0;
      phase_d = '0;
    end else if (frame_start_i) begin
      if (cnt_q == FC_W'(CYC_FRAMES - 1)) begin
        cnt_d   = '0;
        phase_d = (phase_q == PH_W'(LEN - 1)) ? '0 : phase_q + 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q   <= '0;
      phase_q <= '0;
    end else begin
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
    end
  end

  assign phase_o = phase_q;

endmodule

// File: rtl/sprite_palette_bank.sv
// Multi-palette colour lookup: index remap for palette cycling, register-file
// palettes with blank-gated staged writes, and a two-stage lookup pipeline.
module sprite_palette_bank
  import sprite_palette_pkg::*;
#(
  parameter int NUM_PAL    = DEF_NUM_PAL,
  parameter int TRANSP_IDX = DEF_TRANSP_IDX,
  parameter int CYC_FIRST  = DEF_CYC_FIRST,
  parameter int CYC_LAST   = DEF_CYC_LAST,
  parameter int CYC_FRAMES = DEF_CYC_FRAMES,
  parameter int PAL_W      = $clog2(NUM_PAL)
) (
  input  logic              Clk,
  input  logic              Reset_n,
  input  logic              pix_valid,
  input  logic [IDX_W-1:0]  pix_index,
  input  logic [PAL_W-1:0]  pix_pal,
  output logic              out_valid,
  output logic [CH_W-1:0]   red,
  output logic [CH_W-1:0]   green,
  output logic [CH_W-1:0]   blue,
  output logic              out_transparent,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [PAL_W-1:0]  wr_pal,
  input  logic [IDX_W-1:0]  wr_index,
  input  logic [3*CH_W-1:0] wr_rgb,
  input  logic              blank,
  input  logic              frame_start,
  input  logic              cyc_en
);

  localparam int LEN  = CYC_LAST - CYC_FIRST + 1;
  localparam int PH_W = width_of(LEN);
  localparam int SW   = IDX_W + 1;

  logic [PH_W-1:0] phase;

  palette_cycle_ctrl #(
    .LEN       (LEN),
    .CYC_FRAMES(CYC_FRAMES),
    .PH_W      (PH_W)
  ) u_cycle (
    .clk_i        (Clk),
    .rst_ni       (Reset_n),
    .frame_start_i(frame_start),
    .cyc_en_i     (cyc_en),
    .phase_o      (phase)
  );

  logic             s1_valid_q, s1_transp_q, s1_transp_d;
  logic [PAL_W-1:0] s1_pal_q, s1_pal_d;
  logic [IDX_W-1:0] s1_eff_q, s1_eff_d;
  logic [SW-1:0]    rot;

  // Rotate only indices inside the cycled window; transparency keys off the raw index.
  always_comb begin
    rot         = '0;
    s1_eff_d    = pix_index;
    s1_transp_d = (pix_index == IDX_W'(TRANSP_IDX));
    s1_pal_d    = (int'(pix_pal) < NUM_PAL) ? pix_pal : '0;
    if (pix_index >= IDX_W'(CYC_FIRST) && pix_index <= IDX_W'(CYC_LAST)) begin
      rot = SW'(pix_index) - SW'(CYC_FIRST) + SW'(phase);
      if (rot >= SW'(LEN)) rot = rot - SW'(LEN);
      s1_eff_d = IDX_W'(rot + SW'(CYC_FIRST));
    end
  end

  logic             pend_q, pend_d;
  logic [PAL_W-1:0] wpal_q;
  logic [IDX_W-1:0] widx_q;
  rgb_t             wrgb_q;
  logic             commit;

  assign commit = pend_q & blank;

  always_comb begin
    pend_d = pend_q;
    if (commit)              pend_d = 1'b0;
    else if (!pend_q && wr_valid) pend_d = 1'b1;
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      pend_q <= 1'b0;
      wpal_q <= '0;
      widx_q <= '0;
      wrgb_q <= '0;
    end else begin
      pend_q <= pend_d;
      if (wr_valid && !pend_q) begin
        wpal_q <= wr_pal;
        widx_q <= wr_index;
        wrgb_q <= wr_rgb;
      end
    end
  end

  assign wr_ready = ~pend_q;

  // Out-of-range palette writes match no row, so they drop silently.
  rgb_t mem_q [NUM_PAL][DEPTH];

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      for (int p = 0; p < NUM_PAL; p++)
        for (int i = 0; i < DEPTH; i++)
          mem_q[p][i] <= default_entry(IDX_W'(i));
    end else if (commit) begin
      for (int p = 0; p < NUM_PAL; p++)
        for (int i = 0; i < DEPTH; i++)
          if (p == int'(wpal_q) && i == int'(widx_q))
            mem_q[p][i] <= wrgb_q;
    end
  end

  logic out_valid_q, out_transp_q;
  rgb_t out_rgb_q;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      s1_valid_q   <= 1'b0;
      s1_transp_q  <= 1'b0;
      s1_pal_q     <= '0;
      s1_eff_q     <= '0;
      out_valid_q  <= 1'b0;
      out_transp_q <= 1'b0;
      out_rgb_q    <= '0;
    end else begin
      s1_valid_q  <= pix_valid;
      out_valid_q <= s1_valid_q;
      if (pix_valid) begin
        s1_transp_q <= s1_transp_d;
        s1_pal_q    <= s1_pal_d;
        s1_eff_q    <= s1_eff_d;
      end
      if (s1_valid_q) begin
        out_rgb_q    <= mem_q[s1_pal_q][s1_eff_q];
        out_transp_q <= s1_transp_q;
      end
    end
  end

  assign out_valid       = out_valid_q;
  assign out_transparent = out_transp_q;
  assign red             = out_rgb_q.r;
  assign green           = out_rgb_q.g;
  assign blue            = out_rgb_q.b;

endmodule

// File: tb/tb_sprite_palette_bank.sv
// Directed bench for sprite_palette_bank: default palettes, gated writes,
// read/commit collision, cycling, streaming and reset during a write.
module tb_sprite_palette_bank;

  logic        Clk = 1'b0;
  logic        Reset_n = 1'b1;
  logic        pix_valid = 1'b0;
  logic [3:0]  pix_index = '0;
  logic [1:0]  pix_pal = '0;
  logic        wr_valid = 1'b0;
  logic [1:0]  wr_pal = '0;
  logic [3:0]  wr_index = '0;
  logic [11:0] wr_rgb = '0;
  logic        blank = 1'b0;
  logic        frame_start = 1'b0;
  logic        cyc_en = 1'b0;

  logic        out_valid, out_transparent, wr_ready;
  logic [3:0]  red, green, blue;
  logic        out_valid3, out_transparent3, wr_ready3;
  logic [3:0]  red3, green3, blue3;

  int checks = 0;
  int errors = 0;

  logic [11:0] model [4][16];
  logic [1:0]  reqPal [64];
  logic [3:0]  reqIdx [64];

  typedef struct {
    logic [1:0]  pal;
    logic [3:0]  idx;
    logic [11:0] rgb;
    logic        transp;
  } vec_t;

  vec_t vecs [6];

  always #5 Clk = ~Clk;

  sprite_palette_bank dut (
    .Clk(Clk), .Reset_n(Reset_n), .pix_valid(pix_valid), .pix_index(pix_index),
    .pix_pal(pix_pal), .out_valid(out_valid), .red(red), .green(green), .blue(blue),
    .out_transparent(out_transparent), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .wr_pal(wr_pal), .wr_index(wr_index), .wr_rgb(wr_rgb), .blank(blank),
    .frame_start(frame_start), .cyc_en(cyc_en)
  );

  sprite_palette_bank #(.NUM_PAL(3)) dut3 (
    .Clk(Clk), .Reset_n(Reset_n), .pix_valid(pix_valid), .pix_index(pix_index),
    .pix_pal(pix_pal), .out_valid(out_valid3), .red(red3), .green(green3), .blue(blue3),
    .out_transparent(out_transparent3), .wr_valid(wr_valid), .wr_ready(wr_ready3),
    .wr_pal(wr_pal), .wr_index(wr_index), .wr_rgb(wr_rgb), .blank(blank),
    .frame_start(frame_start), .cyc_en(cyc_en)
  );

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] outWord();
    return {18'd0, out_valid, out_transparent, red, green, blue};
  endfunction

  function automatic logic [31:0] expWord(input logic [11:0] rgb, input logic transp);
    return {18'd0, 1'b1, transp, rgb};
  endfunction

  task automatic applyStimulus(input logic [1:0] pal, input logic [3:0] idx);
    pix_valid = 1'b1;
    pix_pal   = pal;
    pix_index = idx;
    tick();
    pix_valid = 1'b0;
    tick();
  endtask

  task automatic framePulse();
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    tick();
  endtask

  task automatic stageWrite(input logic [1:0] pal, input logic [3:0] idx, input logic [11:0] rgb);
    wr_valid = 1'b1;
    wr_pal   = pal;
    wr_index = idx;
    wr_rgb   = rgb;
    tick();
    wr_valid = 1'b0;
  endtask

  initial begin
    for (int p = 0; p < 4; p++)
      for (int i = 0; i < 16; i++) begin
        logic [3:0] c;
        c = 4'(i);
        model[p][i] = {c, c, c};
      end

    vecs[0] = '{pal: 2'd2, idx: 4'd9,  rgb: 12'h999, transp: 1'b0};
    vecs[1] = '{pal: 2'd0, idx: 4'd0,  rgb: 12'h000, transp: 1'b1};
    vecs[2] = '{pal: 2'd3, idx: 4'd15, rgb: 12'hFFF, transp: 1'b0};
    vecs[3] = '{pal: 2'd1, idx: 4'd7,  rgb: 12'h777, transp: 1'b0};
    vecs[4] = '{pal: 2'd2, idx: 4'd3,  rgb: 12'h333, transp: 1'b0};
    vecs[5] = '{pal: 2'd3, idx: 4'd1,  rgb: 12'h111, transp: 1'b0};

    #2 Reset_n = 1'b0;
    #18;
    checkOutput("reset_outputs", outWord(), 32'd0);
    checkOutput("reset_wr_ready", {31'd0, wr_ready}, 32'd1);
    #2 Reset_n = 1'b1;
    tick();

    for (int v = 0; v < 6; v++) begin
      applyStimulus(vecs[v].pal, vecs[v].idx);
      checkOutput($sformatf("default_vec%0d", v), outWord(), expWord(vecs[v].rgb, vecs[v].transp));
    end

    stageWrite(2'd1, 4'd5, 12'hFC7);
    checkOutput("wr_ready_pending", {31'd0, wr_ready}, 32'd0);
    applyStimulus(2'd1, 4'd5);
    checkOutput("read_before_commit", outWord(), expWord(12'h555, 1'b0));
    checkOutput("wr_ready_still_pending", {31'd0, wr_ready}, 32'd0);
    blank = 1'b1;
    tick();
    blank = 1'b0;
    model[1][5] = 12'hFC7;
    checkOutput("wr_ready_after_commit", {31'd0, wr_ready}, 32'd1);
    applyStimulus(2'd1, 4'd5);
    checkOutput("read_after_commit", outWord(), expWord(12'hFC7, 1'b0));

    stageWrite(2'd0, 4'd4, 12'hAAA);
    pix_valid = 1'b1;
    pix_pal   = 2'd0;
    pix_index = 4'd4;
    tick();
    blank = 1'b1;
    tick();
    pix_valid = 1'b0;
    blank = 1'b0;
    model[0][4] = 12'hAAA;
    checkOutput("collision_old", outWord(), expWord(12'h444, 1'b0));
    tick();
    checkOutput("collision_new", outWord(), expWord(12'hAAA, 1'b0));

    cyc_en = 1'b1;
    for (int f = 0; f < 7; f++) framePulse();
    applyStimulus(2'd2, 4'd3);
    checkOutput("cyc_7_frames", outWord(), expWord(12'h333, 1'b0));
    framePulse();
    applyStimulus(2'd2, 4'd3);
    checkOutput("cyc_p1_idx3", outWord(), expWord(12'h111, 1'b0));
    applyStimulus(2'd2, 4'd1);
    checkOutput("cyc_p1_idx1", outWord(), expWord(12'h222, 1'b0));
    applyStimulus(2'd2, 4'd2);
    checkOutput("cyc_p1_idx2", outWord(), expWord(12'h333, 1'b0));
    applyStimulus(2'd2, 4'd7);
    checkOutput("cyc_p1_idx7", outWord(), expWord(12'h777, 1'b0));
    for (int f = 0; f < 16; f++) framePulse();
    applyStimulus(2'd2, 4'd3);
    checkOutput("cyc_wrap_p0", outWord(), expWord(12'h333, 1'b0));
    for (int f = 0; f < 7; f++) framePulse();
    pix_valid = 1'b1;
    pix_pal   = 2'd2;
    pix_index = 4'd3;
    frame_start = 1'b1;
    tick();
    pix_valid = 1'b0;
    frame_start = 1'b0;
    tick();
    checkOutput("cyc_coincident_pre_phase", outWord(), expWord(12'h333, 1'b0));
    applyStimulus(2'd2, 4'd3);
    checkOutput("cyc_post_edge_phase", outWord(), expWord(12'h111, 1'b0));
    cyc_en = 1'b0;
    tick();
    applyStimulus(2'd2, 4'd3);
    checkOutput("cyc_disable_clears", outWord(), expWord(12'h333, 1'b0));

    for (int t = 0; t < 64; t++) begin
      reqPal[t] = 2'($urandom_range(3, 0));
      reqIdx[t] = 4'($urandom_range(15, 0));
    end
    for (int t = 0; t <= 64; t++) begin
      if (t < 64) begin
        pix_valid = 1'b1;
        pix_pal   = reqPal[t];
        pix_index = reqIdx[t];
      end else begin
        pix_valid = 1'b0;
      end
      tick();
      if (t >= 1)
        checkOutput($sformatf("stream%0d", t - 1), outWord(),
                    expWord(model[reqPal[t-1]][reqIdx[t-1]], reqIdx[t-1] == 4'd0));
    end
    tick();
    checkOutput("stream_hold", outWord(),
                {18'd0, 1'b0, reqIdx[63] == 4'd0, model[reqPal[63]][reqIdx[63]]});

    applyStimulus(2'd3, 4'd4);
    checkOutput("pal3_on_4pal", outWord(), expWord(12'h444, 1'b0));
    checkOutput("pal3_on_3pal_reads_pal0",
                {18'd0, out_valid3, out_transparent3, red3, green3, blue3},
                expWord(12'hAAA, 1'b0));

    stageWrite(2'd2, 4'd6, 12'h123);
    checkOutput("pending_before_reset", {31'd0, wr_ready}, 32'd0);
    #2 Reset_n = 1'b0;
    #2;
    checkOutput("midreset_wr_ready", {31'd0, wr_ready}, 32'd1);
    checkOutput("midreset_outputs", outWord(), 32'd0);
    #2 Reset_n = 1'b1;
    tick();
    blank = 1'b1;
    applyStimulus(2'd2, 4'd6);
    checkOutput("reset_discards_pending", outWord(), expWord(12'h666, 1'b0));
    applyStimulus(2'd1, 4'd5);
    checkOutput("reset_reverts_palette", outWord(), expWord(12'h555, 1'b0));
    blank = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
